// File: rtl/truth_pkg.sv
// Shared definitions for the truth-table checker: gate encodings, FSM states,
// the captured-row layout and the reference gate function.
package truth_pkg;

  typedef enum logic [2:0] {
    OP_NAND = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NOTA = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic a;
    logic b;
    logic out;
  } row_t;

  // Reserved op yields 0 here; the checker flags every such row as a mismatch.
  function automatic logic gate_exp(input op_e op, input logic a, input logic b);
    case (op)
      OP_NAND: gate_exp = ~(a & b);
      OP_AND:  gate_exp = a & b;
      OP_OR:   gate_exp = a | b;
      OP_XOR:  gate_exp = a ^ b;
      OP_NOTA: gate_exp = ~a;
      OP_NOR:  gate_exp = ~(a | b);
      OP_XNOR: gate_exp = ~(a ^ b);
      default: gate_exp = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_ref.sv
// Combinational reference gate: expected output for one row under a given op.
module gate_ref
  import truth_pkg::*;
(
  input  op_e  op,
  input  logic a,
  input  logic b,
  output logic exp
);

  assign exp = gate_exp(op, a, b);

endmodule

// File: rtl/truth_table_checker.sv
// Streams truth-table rows against a reference gate, counting rows, mismatches
// and input coverage, and capturing the first failing row.
module truth_table_checker
  import truth_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] expect_rows,
  input  logic             row_valid,
  output logic             row_ready,
  input  logic             row_a,
  input  logic             row_b,
  input  logic             row_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] row_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [3:0]       cov,
  output logic             fail_seen,
  output logic [CNT_W-1:0] fail_idx,
  output logic [2:0]       fail_row
);

  state_e           r_state;
  state_e           w_next;
  op_e              r_op;
  logic [CNT_W-1:0] r_exp_rows;
  logic [CNT_W-1:0] r_row_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_fail_idx;
  logic [3:0]       r_cov;
  logic             r_fail_seen;
  row_t             r_fail_row;

  logic             w_start_ok;
  logic             w_accept;
  logic             w_exp;
  logic             w_mis;
  logic             w_last;
  logic [CNT_W-1:0] w_row_inc;
  logic [CNT_W-1:0] w_err_inc;

  gate_ref u_gate_ref (
    .op  (r_op),
    .a   (row_a),
    .b   (row_b),
    .exp (w_exp)
  );

  assign w_start_ok = start && (r_state != S_RUN);
  assign w_accept   = row_valid && (r_state == S_RUN);
  assign w_mis      = (r_op == OP_RSVD) || (row_out != w_exp);
  assign w_row_inc  = (r_row_cnt == '1) ? r_row_cnt : r_row_cnt + 1'b1;
  assign w_err_inc  = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + 1'b1;
  assign w_last     = w_accept && (w_row_inc == r_exp_rows);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; a zero-length run skips straight to DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_next = (expect_rows == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (w_last) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from registered state only
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    row_ready = 1'b0;
    pass      = 1'b0;
    case (r_state)
      S_RUN: begin
        busy      = 1'b1;
        row_ready = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        pass = (r_err_cnt == '0) && (r_cov == 4'hF);
      end
      default: ;
    endcase
  end

  // Run datapath: cleared on an accepted start, updated per accepted row
  always_ff @(posedge clk) begin
    if (reset) begin
      r_op        <= OP_NAND;
      r_exp_rows  <= '0;
      r_row_cnt   <= '0;
      r_err_cnt   <= '0;
      r_cov       <= '0;
      r_fail_seen <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_row  <= '0;
    end else if (w_start_ok) begin
      r_op        <= op_e'(op);
      r_exp_rows  <= expect_rows;
      r_row_cnt   <= '0;
      r_err_cnt   <= '0;
      r_cov       <= '0;
      r_fail_seen <= 1'b0;
      r_fail_idx  <= '0;
      r_fail_row  <= '0;
    end else if (w_accept) begin
      r_row_cnt              <= w_row_inc;
      r_cov[{row_a, row_b}]  <= 1'b1;
      if (w_mis) begin
        r_err_cnt <= w_err_inc;
        if (!r_fail_seen) begin
          r_fail_seen <= 1'b1;
          r_fail_idx  <= r_row_cnt;
          r_fail_row  <= '{a: row_a, b: row_b, out: row_out};
        end
      end
    end
  end

  assign row_cnt   = r_row_cnt;
  assign err_cnt   = r_err_cnt;
  assign cov       = r_cov;
  assign fail_seen = r_fail_seen;
  assign fail_idx  = r_fail_idx;
  assign fail_row  = r_fail_row;

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench: one 8-bit-counter checker for the main scenarios and a
// 2-bit-counter checker for reserved-op and zero-length runs.
module tb_truth_table_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       start, row_valid, row_a, row_b, row_out;
  logic [2:0] op;
  logic [7:0] exp_rows;
  logic       row_ready, busy, done, pass, fail_seen;
  logic [7:0] row_cnt, err_cnt, fail_idx;
  logic [3:0] cov;
  logic [2:0] fail_row;

  logic       start2, rv2, a2, b2, o2;
  logic [2:0] op2;
  logic [1:0] exp2;
  logic       rr2, busy2, done2, pass2, fs2;
  logic [1:0] rc2, ec2, fi2;
  logic [3:0] cov2;
  logic [2:0] fr2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  truth_table_checker #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .expect_rows(exp_rows),
    .row_valid(row_valid), .row_ready(row_ready), .row_a(row_a), .row_b(row_b),
    .row_out(row_out), .busy(busy), .done(done), .pass(pass), .row_cnt(row_cnt),
    .err_cnt(err_cnt), .cov(cov), .fail_seen(fail_seen), .fail_idx(fail_idx),
    .fail_row(fail_row)
  );

  truth_table_checker #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .op(op2), .expect_rows(exp2),
    .row_valid(rv2), .row_ready(rr2), .row_a(a2), .row_b(b2),
    .row_out(o2), .busy(busy2), .done(done2), .pass(pass2), .row_cnt(rc2),
    .err_cnt(ec2), .cov(cov2), .fail_seen(fs2), .fail_idx(fi2),
    .fail_row(fr2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_start(input logic [2:0] o, input logic [7:0] n);
    start = 1'b1; op = o; exp_rows = n;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic a, input logic b, input logic o);
    row_a = a; row_b = b; row_out = o; row_valid = 1'b1;
    step();
    row_valid = 1'b0;
  endtask

  task automatic send2(input logic a, input logic b, input logic o);
    a2 = a; b2 = b; o2 = o; rv2 = 1'b1;
    step();
    rv2 = 1'b0;
  endtask

  initial begin
    int  idx, cyc;
    logic hs;
    reset = 1'b1; start = 0; op = 0; exp_rows = 0; row_valid = 0;
    row_a = 0; row_b = 0; row_out = 0;
    start2 = 0; op2 = 0; exp2 = 0; rv2 = 0; a2 = 0; b2 = 0; o2 = 0;
    repeat (3) step();

    // Reset state
    chk("rst_busy", busy, 0);       chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);       chk("rst_ready", row_ready, 0);
    chk("rst_rowcnt", row_cnt, 0);  chk("rst_errcnt", err_cnt, 0);
    chk("rst_cov", cov, 0);         chk("rst_fseen", fail_seen, 0);
    chk("rst_fidx", fail_idx, 0);   chk("rst_frow", fail_row, 0);
    chk("rst2_done", done2, 0);     chk("rst2_rowcnt", rc2, 0);
    reset = 1'b0;
    step();

    // NAND, all four rows correct
    run_start(3'd0, 8'd4);
    chk("nand_busy", busy, 1); chk("nand_ready", row_ready, 1); chk("nand_cnt0", row_cnt, 0);
    send(0, 0, 1); send(0, 1, 1); send(1, 0, 1); send(1, 1, 0);
    chk("nand_done", done, 1);   chk("nand_busy_off", busy, 0);
    chk("nand_ready_off", row_ready, 0);
    chk("nand_pass", pass, 1);   chk("nand_err", err_cnt, 0);
    chk("nand_cov", cov, 4'hF);  chk("nand_rows", row_cnt, 4);
    chk("nand_fseen", fail_seen, 0);
    // Rows offered in DONE are not accepted
    row_valid = 1'b1; row_a = 0; row_b = 0; row_out = 0;
    step(); step();
    row_valid = 1'b0;
    chk("done_stable_rows", row_cnt, 4); chk("done_stable_err", err_cnt, 0);
    chk("done_stable_done", done, 1);

    // NAND with a bad third row, restarted from DONE
    run_start(3'd0, 8'd4);
    chk("restart_clear", row_cnt, 0);
    send(0, 0, 1); send(0, 1, 1); send(1, 0, 0); send(1, 1, 0);
    chk("bad_done", done, 1);      chk("bad_err", err_cnt, 1);
    chk("bad_fseen", fail_seen, 1); chk("bad_fidx", fail_idx, 2);
    chk("bad_frow", fail_row, 3'b100); chk("bad_pass", pass, 0);

    // XOR, three rows, incomplete coverage
    run_start(3'd3, 8'd3);
    send(0, 0, 0); send(0, 1, 1); send(1, 0, 1);
    chk("xor_done", done, 1); chk("xor_err", err_cnt, 0);
    chk("xor_cov", cov, 4'h7); chk("xor_pass", pass, 0);

    // OR with random stalls and an ignored mid-run start
    run_start(3'd2, 8'd5);
    idx = 0; cyc = 0;
    while (idx < 5 && cyc < 200) begin
      row_valid = ($urandom_range(0, 3) != 0);
      row_a = idx[1]; row_b = idx[0]; row_out = idx[1] | idx[0];
      start = (cyc == 3); op = 3'd7; exp_rows = 8'd2;
      hs = row_valid && row_ready;
      step();
      start = 1'b0;
      if (hs) idx++;
      cyc++;
    end
    row_valid = 1'b0;
    chk("stall_handshakes", idx, 5);
    chk("stall_done", done, 1);  chk("stall_rows", row_cnt, 5);
    chk("stall_err", err_cnt, 0); chk("stall_cov", cov, 4'hF);
    chk("stall_pass", pass, 1);
    row_valid = 1'b1;
    step(); step(); step();
    chk("stall_ready_off", row_ready, 0); chk("stall_rows_hold", row_cnt, 5);
    row_valid = 1'b0;

    // Reset mid-run discards partial progress
    run_start(3'd0, 8'd4);
    send(0, 0, 1); send(1, 1, 1);
    chk("pre_rst_err", err_cnt, 1);
    reset = 1'b1;
    step();
    chk("mid_rst_busy", busy, 0);   chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", row_ready, 0); chk("mid_rst_rows", row_cnt, 0);
    chk("mid_rst_err", err_cnt, 0); chk("mid_rst_cov", cov, 0);
    chk("mid_rst_fseen", fail_seen, 0); chk("mid_rst_frow", fail_row, 0);
    reset = 1'b0;
    step();
    run_start(3'd1, 8'd4);
    chk("fresh_rows0", row_cnt, 0);
    send(0, 0, 0);
    chk("fresh_rows1", row_cnt, 1); chk("fresh_cov1", cov, 4'h1);
    send(0, 1, 0); send(1, 0, 0); send(1, 1, 1);
    chk("fresh_done", done, 1); chk("fresh_pass", pass, 1); chk("fresh_rows", row_cnt, 4);

    // Narrow counters: reserved op fails every row
    start2 = 1'b1; op2 = 3'd7; exp2 = 2'd3;
    step();
    start2 = 1'b0;
    chk("rsvd_busy", busy2, 1);
    send2(0, 0, 1); send2(0, 1, 1); send2(1, 0, 1);
    chk("rsvd_done", done2, 1);  chk("rsvd_err", ec2, 3);
    chk("rsvd_rows", rc2, 3);    chk("rsvd_pass", pass2, 0);
    chk("rsvd_fidx", fi2, 0);    chk("rsvd_frow", fr2, 3'b001);

    // Zero-length run goes straight to DONE without passing
    start2 = 1'b1; op2 = 3'd1; exp2 = 2'd0;
    step();
    start2 = 1'b0;
    chk("zero_done", done2, 1); chk("zero_busy", busy2, 0);
    chk("zero_pass", pass2, 0); chk("zero_rows", rc2, 0);
    chk("zero_err", ec2, 0);    chk("zero_fseen", fs2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
